gate_stream_reduce: RTL and testbench

Parametrised sequential successor of the combinational two-input gates. It reduces a stream of WIDTH-bit words with a selectable bitwise logic operation (AND/OR/XOR and their inverted forms) over a programmable number of beats. Input and output use valid/ready handshakes. It serves as the generic registered logic-reduction unit for the next assignments.

---
 rtl/gate_stream_reduce.sv | 268 ++++++++++++++++++++++++++
 tb/tb_gate_stream_reduce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_stream_reduce.sv
// ---------------------------------------------------------------------------
// gate_stream_reduce
//
// Registered logic-reduction unit. An operation is armed with a start pulse,
// which latches the logic operation and a beat count. The block then folds
// that many WIDTH-bit words, received over a valid/ready handshake, into an
// accumulator with the selected bitwise operation. The final result, inverted
// for the NAND/NOR/XNOR variants, is offered on a valid/ready output. The
// result is held until the consumer accepts it, and then the block returns
// to idle.
//
// Operations (op):
//   0 AND   1 OR   2 XOR   3 NAND   4 NOR   5 XNOR   6/7 reserved -> OR
//
// Parameters:
//   WIDTH  data word width in bits
//   CNT_W  width of len and of the beat counter (max 2^CNT_W-1 beats)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   start    in   begin an operation (sampled only while idle)
//   op       in   operation select, latched on start
//   len      in   number of beats to reduce, latched on start
//   a        in   input data word
//   a_valid  in   a holds a valid beat
//   a_ready  out  block accepts a beat (accumulating state only)
//   y        out  registered result
//   y_valid  out  y holds a result
//   y_ready  in   consumer accepts the result
//   busy     out  high while accumulating or holding a result
//   y_bit    out  (only with GATE_STREAM_REDUCE_BITRED_EN) one-bit reduction
//                 of the final pre-inversion accumulator across all its bits,
//                 inverted for the inverting ops; registered together with y
//
// Optional feature macro: GATE_STREAM_REDUCE_BITRED_EN
//   Undefined (default): y_bit and its logic are absent.
//   Defined:             y_bit is added as described above.
//
// All outputs are registers or pure decodes of the state register, so no
// combinational path exists from any input to any output.
// ---------------------------------------------------------------------------
module gate_stream_reduce #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
`ifdef GATE_STREAM_REDUCE_BITRED_EN
  output logic             y_bit,
`endif
  output logic             busy
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Base operation encoding (inversion is carried as a separate flag)
  localparam logic [1:0] BASE_AND = 2'd0;
  localparam logic [1:0] BASE_OR  = 2'd1;
  localparam logic [1:0] BASE_XOR = 2'd2;

  // -------------------------------------------------------------------------
  // Operation decode helpers
  // -------------------------------------------------------------------------

  // Reserved codes 6/7 fall through to OR.
  function automatic logic [1:0] base_of(input logic [2:0] o);
    logic [1:0] b;
    case (o)
      3'd0, 3'd3: b = BASE_AND;
      3'd2, 3'd5: b = BASE_XOR;
      default:    b = BASE_OR;
    endcase
    return b;
  endfunction

  function automatic logic inv_of(input logic [2:0] o);
    return (o == 3'd3) || (o == 3'd4) || (o == 3'd5);
  endfunction

  // Identity element: folding it with any word leaves the word unchanged.
  function automatic logic [WIDTH-1:0] identity_of(input logic [1:0] b);
    return (b == BASE_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       b,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (b)
      BASE_AND: r = x & z;
      BASE_XOR: r = x ^ z;
      default:  r = x | z;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] invert_if(input logic             inv,
                                                 input logic [WIDTH-1:0] x);
    return x ^ {WIDTH{inv}};
  endfunction

`ifdef GATE_STREAM_REDUCE_BITRED_EN
  // Collapse a word to one bit with the base operation, then apply inversion.
  function automatic logic bit_reduce(input logic [1:0]       b,
                                      input logic             inv,
                                      input logic [WIDTH-1:0] x);
    logic r;
    case (b)
      BASE_AND: r = &x;
      BASE_XOR: r = ^x;
      default:  r = |x;
    endcase
    return r ^ inv;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [1:0]       base_q,    base_d;
  logic             inv_q,     inv_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] y_q,       y_d;
  logic             y_valid_q, y_valid_d;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
  logic             y_bit_q,   y_bit_d;
`endif

  // Values used by more than one branch of the next-state logic.
  logic [1:0]       start_base;
  logic             start_inv;
  logic [WIDTH-1:0] start_ident;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    start_base  = base_of(op);
    start_inv   = inv_of(op);
    start_ident = identity_of(start_base);
    acc_next    = apply_op(base_q, acc_q, a);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
    y_bit_d   = y_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = start_base;
          inv_d  = start_inv;
          acc_d  = start_ident;
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_ACC;
          end else begin
            // Empty reduction: the result is the identity itself.
            y_d       = invert_if(start_inv, start_ident);
            y_valid_d = 1'b1;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
            y_bit_d   = bit_reduce(start_base, start_inv, start_ident);
`endif
            state_d   = S_DONE;
          end
        end
      end

      S_ACC: begin
        // a_ready is high throughout this state, so a_valid alone marks a
        // transfer.
        if (a_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Last beat: publish the folded value, including this beat,
            // on the same edge that accepts it.
            y_d       = invert_if(inv_q, acc_next);
            y_valid_d = 1'b1;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
            y_bit_d   = bit_reduce(base_q, inv_q, acc_next);
`endif
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        // y_valid is always set in this state, so y_ready completes it.
        // y keeps its value after the handshake.
        if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        y_valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= BASE_AND;
      inv_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
      y_bit_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
      y_bit_q   <= y_bit_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign a_ready = (state_q == S_ACC);
  assign busy    = (state_q == S_ACC) || (state_q == S_DONE);
  assign y       = y_q;
  assign y_valid = y_valid_q;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
  assign y_bit   = y_bit_q;
`endif

endmodule

// File: tb/tb_gate_stream_reduce.sv
module tb_gate_stream_reduce;

  localparam int WIDTH = 8;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             busy;
`ifdef GATE_STREAM_REDUCE_BITRED_EN
  logic             y_bit;
`endif

  int checks = 0;
  int errors = 0;

  gate_stream_reduce #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .len     (len),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
`ifdef GATE_STREAM_REDUCE_BITRED_EN
    .y_bit   (y_bit),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] o, input logic [CNT_W-1:0] l);
    start = 1'b1;
    op    = o;
    len   = l;
    tick();
    start = 1'b0;
    op    = 3'd7;
    len   = '1;
  endtask

  // Present one beat and hold it until accepted, within a bounded wait.
  task automatic feed(input logic [WIDTH-1:0] d);
    bit done;
    done    = 1'b0;
    a       = d;
    a_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (a_ready) done = 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL feed_timeout: beat %0h got a_ready=0, required 1", d);
    end
    a_valid = 1'b0;
    a       = 8'h00;
  endtask

  task automatic handshake();
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (y !== 8'h00)     begin errors++; $display("FAIL reset_y: got %0h required 00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %0b required 0", y_valid); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %0b required 0", a_ready); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  task automatic test_or_back_to_back();
    do_start(3'd1, 5'd4);
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL or_busy_after_start: got %0b required 1", busy); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL or_a_ready: got %0b required 1", a_ready); end
    feed(8'h01);
    feed(8'h02);
    feed(8'h04);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL or_early_valid: got %0b required 0", y_valid); end
    feed(8'h80);
    checks++; if (y !== 8'h87)      begin errors++; $display("FAIL or_y: got %0h required 87", y); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL or_y_valid: got %0b required 1", y_valid); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL or_done_a_ready: got %0b required 0", a_ready); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL or_done_busy: got %0b required 1", busy); end
    handshake();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL or_after_hs_valid: got %0b required 0", y_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL or_after_hs_busy: got %0b required 0", busy); end
    checks++; if (y !== 8'h87)      begin errors++; $display("FAIL or_y_kept: got %0h required 87", y); end
  endtask

  task automatic test_and_nand();
    do_start(3'd0, 5'd3);
    feed(8'hFF); feed(8'hF0); feed(8'h3C);
    checks++; if (y !== 8'h30 || y_valid !== 1'b1) begin errors++; $display("FAIL and_y: got %0h/%0b required 30/1", y, y_valid); end
`ifdef GATE_STREAM_REDUCE_BITRED_EN
    checks++; if (y_bit !== 1'b0) begin errors++; $display("FAIL and_y_bit: got %0b required 0", y_bit); end
`endif
    handshake();
    tick();
    do_start(3'd3, 5'd3);
    feed(8'hFF); feed(8'hF0); feed(8'h3C);
    checks++; if (y !== 8'hCF || y_valid !== 1'b1) begin errors++; $display("FAIL nand_y: got %0h/%0b required CF/1", y, y_valid); end
`ifdef GATE_STREAM_REDUCE_BITRED_EN
    checks++; if (y_bit !== 1'b1) begin errors++; $display("FAIL nand_y_bit: got %0b required 1", y_bit); end
`endif
    handshake();
  endtask

  task automatic test_xor_idle();
    logic [2:0]       ops [2];
    logic [WIDTH-1:0] exp [2];
    ops[0] = 3'd2; exp[0] = 8'hFF;
    ops[1] = 3'd5; exp[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tick();
      do_start(ops[k], 5'd2);
      feed(8'hAA);
      for (int i = 0; i < 3; i++) tick();
      checks++; if (y_valid !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL xor_idle_state op%0d: got valid=%0b ready=%0b required 0/1", ops[k], y_valid, a_ready); end
      feed(8'h55);
      checks++; if (y !== exp[k] || y_valid !== 1'b1) begin errors++; $display("FAIL xor_y op%0d: got %0h/%0b required %0h/1", ops[k], y, y_valid, exp[k]); end
      handshake();
    end
  endtask

  task automatic test_len_zero();
    logic [2:0]       ops [3];
    logic [WIDTH-1:0] exp [3];
    logic             eb  [3];
    ops[0] = 3'd0; exp[0] = 8'hFF; eb[0] = 1'b1;
    ops[1] = 3'd4; exp[1] = 8'hFF; eb[1] = 1'b1;
    ops[2] = 3'd2; exp[2] = 8'h00; eb[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      do_start(ops[k], 5'd0);
      checks++; if (y !== exp[k] || y_valid !== 1'b1) begin errors++; $display("FAIL len0_y op%0d: got %0h/%0b required %0h/1", ops[k], y, y_valid, exp[k]); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL len0_a_ready op%0d: got %0b required 0", ops[k], a_ready); end
`ifdef GATE_STREAM_REDUCE_BITRED_EN
      checks++; if (y_bit !== eb[k]) begin errors++; $display("FAIL len0_y_bit op%0d: got %0b required %0b", ops[k], y_bit, eb[k]); end
`else
      if (eb[k] !== 1'b0 && eb[k] !== 1'b1) $display("len0 bit table entry %0d is undefined", k);
`endif
      handshake();
      checks++; if (a_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len0_after_hs op%0d: got ready=%0b busy=%0b required 0/0", ops[k], a_ready, busy); end
    end
  endtask

  task automatic test_backpressure();
    tick();
    do_start(3'd1, 5'd1);
    feed(8'h5A);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op = 3'd0; len = 5'd0;
      tick();
      checks++; if (y !== 8'h5A || y_valid !== 1'b1 || a_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle%0d: got y=%0h v=%0b r=%0b b=%0b required 5A/1/0/1", i, y, y_valid, a_ready, busy);
      end
    end
    start = 1'b0;
    handshake();
    checks++; if (y_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%0b b=%0b required 0/0", y_valid, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_stays: got busy=%0b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_start(3'd1, 5'd4);
    feed(8'h10);
    feed(8'h20);
    a = 8'h40; a_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b0; a = 8'h00;
    checks++; if (y !== 8'h00 || y_valid !== 1'b0 || a_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got y=%0h v=%0b r=%0b b=%0b required 00/0/0/0", y, y_valid, a_ready, busy);
    end
    do_start(3'd1, 5'd1);
    feed(8'h0F);
    checks++; if (y !== 8'h0F || y_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_new: got %0h/%0b required 0F/1", y, y_valid); end
    handshake();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; len = '0;
    a = '0; a_valid = 1'b0; y_ready = 1'b0;
    test_reset();
    test_or_back_to_back();
    test_and_nand();
    test_xor_idle();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
